// File: rtl/dht11_reader.sv
// rtl/dht11_reader.sv - DHT11 single-wire bus master producing the 40-bit tem_data frame
// Drives the host start pulse, times ack and data-bit widths in 1 us ticks, checks the frame sum.
module dht11_reader #(
   parameter int CLK_HZ        = 50_000_000,
   parameter int START_LOW_US  = 20000,
   parameter int BIT_THRESH_US = 40,
   parameter int TIMEOUT_US    = 200
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        start,
   input  logic        dht_in,
   output logic        dht_oe,
   output logic        busy,
   output logic [39:0] tem_data,
   output logic        valid,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam logic [15:0] PRE_MAX    = 16'(CLK_HZ / 1_000_000 - 1);
   localparam logic [15:0] START_CNT  = 16'(START_LOW_US);
   localparam logic [15:0] THRESH_CNT = 16'(BIT_THRESH_US);
   localparam logic [15:0] TMO_CNT    = 16'(TIMEOUT_US);

   typedef enum logic [2:0] {
      S_IDLE, S_START_LOW, S_WAIT_ACK, S_ACK_LOW,
      S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_sync;
   logic        r_level;
   logic [15:0] r_pre;
   logic [15:0] r_us;
   logic [39:0] r_shift;
   logic [5:0]  r_bits;
   logic [39:0] r_data;
   logic        r_valid;
   logic        r_err;
   logic [1:0]  r_code;

   logic        w_rise;
   logic        w_fall;
   logic        w_tick;
   logic        w_accept;
   logic        w_bit;
   logic [7:0]  w_sum;
   logic        w_shift_en;
   logic        w_good;
   logic        w_fail;
   logic [1:0]  w_fail_code;

   // r_level is the edge register behind the two-flop synchronizer
   assign w_rise   = r_sync[1] & ~r_level;
   assign w_fall   = ~r_sync[1] & r_level;
   assign w_tick   = (r_pre == PRE_MAX);
   assign w_accept = (r_state == S_IDLE) && start;
   assign w_bit    = (r_us > THRESH_CNT);
   assign w_sum    = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

   always_ff @(posedge clk) begin
      if (nRST) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_shift_en  = 1'b0;
      w_good      = 1'b0;
      w_fail      = 1'b0;
      w_fail_code = 2'd0;
      case (r_state)
         S_IDLE:      if (start) w_next = S_START_LOW;
         S_START_LOW: if (r_us == START_CNT) w_next = S_WAIT_ACK;
         S_WAIT_ACK:  if (w_fall) w_next = S_ACK_LOW;
         S_ACK_LOW:   if (w_rise) w_next = S_ACK_HIGH;
         S_ACK_HIGH:  if (w_fall) w_next = S_BIT_LOW;
         S_BIT_LOW:   if (w_rise) w_next = S_BIT_HIGH;
         S_BIT_HIGH: begin
            if (w_fall) begin
               w_shift_en = 1'b1;
               w_next     = (r_bits == 6'd39) ? S_CHECK : S_BIT_LOW;
            end
         end
         S_CHECK: begin
            w_next = S_IDLE;
            if (w_sum == r_shift[7:0]) begin
               w_good = 1'b1;
            end else begin
               w_fail      = 1'b1;
               w_fail_code = 2'd3;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // a stuck bus wins over any edge seen in the same cycle
      if (r_us == TMO_CNT) begin
         if (r_state inside {S_WAIT_ACK, S_ACK_LOW, S_ACK_HIGH}) begin
            w_next      = S_IDLE;
            w_fail      = 1'b1;
            w_fail_code = 2'd1;
            w_shift_en  = 1'b0;
         end else if (r_state inside {S_BIT_LOW, S_BIT_HIGH}) begin
            w_next      = S_IDLE;
            w_fail      = 1'b1;
            w_fail_code = 2'd2;
            w_shift_en  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (nRST) begin
         r_sync  <= 2'b11;
         r_level <= 1'b1;
         r_pre   <= 16'd0;
         r_us    <= 16'd0;
         r_shift <= 40'd0;
         r_bits  <= 6'd0;
         r_data  <= 40'd0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_code  <= 2'd0;
      end else begin
         r_sync  <= {r_sync[0], dht_in};
         r_level <= r_sync[1];
         r_pre   <= (w_accept || w_tick) ? 16'd0 : r_pre + 16'd1;
         if (w_next != r_state)
            r_us <= 16'd0;
         else if (w_tick && r_us != 16'hFFFF)
            r_us <= r_us + 16'd1;
         if (w_accept) begin
            r_bits <= 6'd0;
            r_code <= 2'd0;
         end
         if (w_shift_en) begin
            r_shift <= {r_shift[38:0], w_bit};
            r_bits  <= r_bits + 6'd1;
         end
         r_valid <= w_good;
         r_err   <= w_fail;
         if (w_good) r_data <= r_shift;
         if (w_fail) r_code <= w_fail_code;
      end
   end

   assign dht_oe   = (r_state == S_START_LOW);
   assign busy     = (r_state != S_IDLE);
   assign tem_data = r_data;
   assign valid    = r_valid;
   assign err      = r_err;
   assign err_code = r_code;

endmodule

// File: tb/tb_dht11_reader.sv
// tb/tb_dht11_reader.sv - table-driven reads against a DHT11 sensor model with a result scoreboard
module tb_dht11_reader;

   logic        clk = 1'b0;
   logic        nRST = 1'b0;
   logic        start = 1'b0;
   logic        sensor_low = 1'b0;
   logic        dht_in;
   logic        dht_oe;
   logic        busy;
   logic [39:0] tem_data;
   logic        valid;
   logic        err;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;
   int bfm_bit = -1;
   logic bfm_done = 1'b0;

   typedef struct {
      logic        is_err;
      logic [1:0]  code;
      logic [39:0] data;
   } sb_t;

   typedef struct {
      logic [39:0] frame;
      int          nbits;
      int          hi0;
      int          hi1;
      logic        extra;
      logic        is_err;
      logic [1:0]  code;
      logic [39:0] data;
   } vec_t;

   sb_t  sb[$];
   sb_t  m_exp;
   vec_t vt[6];

   // open-drain bus with pull-up: either side may pull it low
   assign dht_in = ~(dht_oe | sensor_low);

   always #1 clk = ~clk;

   dht11_reader #(
      .CLK_HZ(2_000_000),
      .START_LOW_US(200),
      .BIT_THRESH_US(40),
      .TIMEOUT_US(200)
   ) dut (
      .clk(clk),
      .nRST(nRST),
      .start(start),
      .dht_in(dht_in),
      .dht_oe(dht_oe),
      .busy(busy),
      .tem_data(tem_data),
      .valid(valid),
      .err(err),
      .err_code(err_code)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s bound expired", name);
   endtask

   // 1 us = 2 clock cycles = 4 time units
   task automatic us(input int n);
      #(n * 4);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic bfm(input logic [39:0] frame, input int nbits, input int hi0, input int hi1);
      int k;
      bfm_done = 1'b0;
      bfm_bit  = -1;
      k = 0;
      while (!dht_oe && k < 100) begin @(posedge clk); k++; end
      k = 0;
      while (dht_oe && k < 2000) begin @(posedge clk); k++; end
      if (k >= 2000) fail_now("bfm_host_release");
      @(negedge clk);
      us(20);
      sensor_low = 1'b1; us(80);
      sensor_low = 1'b0; us(80);
      for (int i = 0; i < nbits; i++) begin
         sensor_low = 1'b1; us(50);
         sensor_low = 1'b0;
         bfm_bit = i;
         us(frame[39-i] ? hi1 : hi0);
      end
      if (nbits == 40) begin
         sensor_low = 1'b1; us(50);
         sensor_low = 1'b0;
      end
      bfm_done = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 20000) begin @(negedge clk); k++; end
      if (k >= 20000) fail_now(name);
   endtask

   task automatic run_read(input vec_t v);
      sb.push_back('{v.is_err, v.code, v.data});
      pulse_start();
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      chk("oe_after_start", {63'd0, dht_oe}, 64'd1);
      if (v.nbits >= 0) begin
         if (v.extra) begin
            fork
               bfm(v.frame, v.nbits, v.hi0, v.hi1);
               begin
                  repeat (1000) @(negedge clk);
                  pulse_start();
                  repeat (3000) @(negedge clk);
                  pulse_start();
               end
            join
         end else begin
            bfm(v.frame, v.nbits, v.hi0, v.hi1);
         end
      end
      wait_idle("read_done");
      repeat (50) @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_oe", {63'd0, dht_oe}, 64'd0);
   endtask

   always @(negedge clk) begin
      if (valid || err) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected valid=%0b err=%0b code=%0d", valid, err, err_code);
         end else begin
            m_exp = sb.pop_front();
            chk("sb_kind", {62'd0, valid, err}, m_exp.is_err ? 64'd1 : 64'd2);
            chk("sb_err_code", {62'd0, err_code}, {62'd0, m_exp.code});
            chk("sb_tem_data", {24'd0, tem_data}, {24'd0, m_exp.data});
            chk("sb_busy_low", {63'd0, busy}, 64'd0);
         end
      end
   end

   initial begin
      #198000;
      $display("FAIL watchdog cycle budget exhausted");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int n;
      int k;
      vt[0] = '{40'h2D00170044, 40, 26, 70, 1'b0, 1'b0, 2'd0, 40'h2D00170044};
      vt[1] = '{40'h2D00170045, 40, 26, 70, 1'b0, 1'b1, 2'd3, 40'h2D00170044};
      vt[2] = '{40'h0000000000, -1, 26, 70, 1'b0, 1'b1, 2'd1, 40'h2D00170044};
      vt[3] = '{40'h2D00170044, 17, 26, 70, 1'b0, 1'b1, 2'd2, 40'h2D00170044};
      vt[4] = '{40'h3A00190053, 40, 26, 70, 1'b1, 1'b0, 2'd0, 40'h3A00190053};
      vt[5] = '{40'h55AA0F0F1D, 40, 35, 50, 1'b0, 1'b0, 2'd0, 40'h55AA0F0F1D};

      nRST = 1'b1;
      repeat (3) @(negedge clk);
      nRST = 1'b0;
      @(negedge clk);
      chk("rst_oe", {63'd0, dht_oe}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_tem_data", {24'd0, tem_data}, 64'd0);
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      chk("rst_err_code", {62'd0, err_code}, 64'd0);

      for (int i = 0; i < 6; i++) run_read(vt[i]);

      // no sensor: err lands START_LOW_US + TIMEOUT_US = 400 us = 800 cycles after start
      sb.push_back('{1'b1, 2'd1, 40'h55AA0F0F1D});
      pulse_start();
      n = 0;
      while (!err && n < 3000) begin @(negedge clk); n++; end
      checks++;
      if (n < 796 || n > 806) begin
         errors++;
         $display("FAIL nosense_latency got=%0d exp=796..806", n);
      end
      chk("nosense_oe", {63'd0, dht_oe}, 64'd0);
      wait_idle("nosense_done");
      repeat (5) @(negedge clk);

      // reset in the middle of a data bit
      pulse_start();
      fork
         bfm(40'h2D00170044, 40, 26, 70);
      join_none
      k = 0;
      while (bfm_bit < 5 && k < 20000) begin @(posedge clk); k++; end
      if (k >= 20000) fail_now("reset_wait_bit");
      us(10);
      @(negedge clk) nRST = 1'b1;
      @(negedge clk);
      chk("midrst_oe", {63'd0, dht_oe}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_tem_data", {24'd0, tem_data}, 64'd0);
      chk("midrst_err_code", {62'd0, err_code}, 64'd0);
      nRST = 1'b0;
      k = 0;
      while (!bfm_done && k < 20000) begin @(negedge clk); k++; end
      if (k >= 20000) fail_now("reset_bfm_done");
      repeat (20) @(negedge clk);
      chk("midrst_stays_idle", {63'd0, busy}, 64'd0);

      run_read(vt[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
